// File: rtl/sgm_line_buf_ctrl_if.sv
// Stream + SRAM bundle for the SGM line-buffer controller.
// Latency: n/a (wires only).
// Backpressure: in_ready/out_ready valid-ready pairs; SRAM pins are unflowed.
// Ports: slave = controller view, master = producer/consumer/SRAM view.
interface sgm_line_buf_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 10
);
    // input pixel stream
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_eol;
    // output pair stream
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_cur;
    logic [DATA_WIDTH-1:0] out_prev;
    logic                  out_prev_vld;
    logic                  out_eol;
    logic                  out_eof;
    logic                  err_eol;
    // SRAM port A (write-only), all controls low-active
    logic [ADDR_WIDTH-1:0] addr_a;
    logic [DATA_WIDTH-1:0] din_a;
    logic                  ce_a;
    logic                  wr_en_a;
    logic [DATA_WIDTH-1:0] bit_en_a;
    // SRAM port B (read-only), controls low-active
    logic [ADDR_WIDTH-1:0] addr_b;
    logic                  ce_b;
    logic                  wr_en_b;
    logic [DATA_WIDTH-1:0] dout_b;

    modport slave (
        input  in_valid, in_data, in_eol, out_ready, dout_b,
        output in_ready, out_valid, out_cur, out_prev, out_prev_vld,
               out_eol, out_eof, err_eol,
               addr_a, din_a, ce_a, wr_en_a, bit_en_a,
               addr_b, ce_b, wr_en_b
    );

    modport master (
        output in_valid, in_data, in_eol, out_ready, dout_b,
        input  in_ready, out_valid, out_cur, out_prev, out_prev_vld,
               out_eol, out_eof, err_eol,
               addr_a, din_a, ce_a, wr_en_a, bit_en_a,
               addr_b, ce_b, wr_en_b
    );
endinterface

// File: rtl/sgm_line_buf_ctrl.sv
// Pairs each pixel with the same-column pixel of the previous row via a one-line SRAM.
// Latency: accepted pixel appears on out_* one cycle later; 1 pair/cycle sustained.
// Backpressure: in_ready = !out_valid || out_ready; one pair in flight, no skid buffer.
// Ports: clk, rst_n (sync, active-low); bus = stream in/out, err_eol, SRAM A/B pins.
module sgm_line_buf_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 10,
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic                clk,
    input  logic                rst_n,
    sgm_line_buf_ctrl_if.slave  bus
);
    localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam logic [ADDR_WIDTH-1:0] COL_LAST = ADDR_WIDTH'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0]      ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

    logic [ADDR_WIDTH-1:0] col_q, col_d;
    logic [ROW_W-1:0]      row_q, row_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_cur_q, out_cur_d;
    logic                  out_eol_q, out_eol_d;
    logic                  out_eof_q, out_eof_d;
    logic                  prev_vld_q, prev_vld_d;
    logic                  err_q, err_d;
    logic                  ce_a_q, ce_a_d;
    logic                  wr_en_a_q, wr_en_a_d;
    logic [DATA_WIDTH-1:0] bit_en_a_q, bit_en_a_d;
    logic [ADDR_WIDTH-1:0] addr_a_q, addr_a_d;
    logic [DATA_WIDTH-1:0] din_a_q, din_a_d;

    logic                  in_ready;
    logic                  accept;
    logic                  last_col;
    logic                  last_row;
    logic [ROW_W-1:0]      row_inc;

    assign in_ready = !out_valid_q || bus.out_ready;
    assign accept   = bus.in_valid && in_ready;
    assign last_col = (col_q == COL_LAST);
    assign last_row = (row_q == ROW_LAST);
    assign row_inc  = last_row ? '0 : row_q + ROW_W'(1);

    always_comb begin
        col_d       = col_q;
        row_d       = row_q;
        out_valid_d = out_valid_q;
        out_cur_d   = out_cur_q;
        out_eol_d   = out_eol_q;
        out_eof_d   = out_eof_q;
        prev_vld_d  = prev_vld_q;
        err_d       = err_q;
        // port A idles unless a write was generated by this cycle's accept
        ce_a_d      = 1'b1;
        wr_en_a_d   = 1'b1;
        bit_en_a_d  = '1;
        addr_a_d    = addr_a_q;
        din_a_d     = din_a_q;

        if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end

        if (accept) begin
            out_valid_d = 1'b1;
            out_cur_d   = bus.in_data;
            out_eol_d   = last_col;
            out_eof_d   = last_col && last_row;
            prev_vld_d  = (row_q != '0);
            // the write lands one cycle after the read of the same column,
            // so the old row is always captured before being overwritten
            ce_a_d      = 1'b0;
            wr_en_a_d   = 1'b0;
            bit_en_a_d  = '0;
            addr_a_d    = col_q;
            din_a_d     = bus.in_data;

            if (bus.in_eol && !last_col) begin
                // early end-of-line: resync to the start of the next row
                err_d = 1'b1;
                col_d = '0;
                row_d = row_inc;
            end else if (last_col) begin
                if (!bus.in_eol) begin
                    err_d = 1'b1;
                end
                col_d = '0;
                row_d = row_inc;
            end else begin
                col_d = col_q + ADDR_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col_q       <= '0;
            row_q       <= '0;
            out_valid_q <= 1'b0;
            out_cur_q   <= '0;
            out_eol_q   <= 1'b0;
            out_eof_q   <= 1'b0;
            prev_vld_q  <= 1'b0;
            err_q       <= 1'b0;
            ce_a_q      <= 1'b1;
            wr_en_a_q   <= 1'b1;
            bit_en_a_q  <= '1;
            addr_a_q    <= '0;
            din_a_q     <= '0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            out_valid_q <= out_valid_d;
            out_cur_q   <= out_cur_d;
            out_eol_q   <= out_eol_d;
            out_eof_q   <= out_eof_d;
            prev_vld_q  <= prev_vld_d;
            err_q       <= err_d;
            ce_a_q      <= ce_a_d;
            wr_en_a_q   <= wr_en_a_d;
            bit_en_a_q  <= bit_en_a_d;
            addr_a_q    <= addr_a_d;
            din_a_q     <= din_a_d;
        end
    end

    assign bus.in_ready     = in_ready;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_cur      = out_cur_q;
    // dout_b holds while stalled since no read issues without an accept
    assign bus.out_prev     = prev_vld_q ? bus.dout_b : '0;
    assign bus.out_prev_vld = prev_vld_q;
    assign bus.out_eol      = out_eol_q;
    assign bus.out_eof      = out_eof_q;
    assign bus.err_eol      = err_q;

    assign bus.addr_a   = addr_a_q;
    assign bus.din_a    = din_a_q;
    assign bus.ce_a     = ce_a_q;
    assign bus.wr_en_a  = wr_en_a_q;
    assign bus.bit_en_a = bit_en_a_q;

    // read of the current column is issued in the accept cycle itself
    assign bus.addr_b  = col_q;
    assign bus.ce_b    = !accept;
    assign bus.wr_en_b = 1'b1;
endmodule

// File: tb/tb_sgm_line_buf_ctrl.sv
module tb_sgm_line_buf_ctrl;
    localparam int DW = 8;
    localparam int AW = 10;
    localparam int W  = 4;
    localparam int H  = 3;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    sgm_line_buf_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    sgm_line_buf_ctrl #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .IMG_WIDTH(W), .IMG_HEIGHT(H)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // one-line SRAM model: read-before-write, low-active controls, 1-cycle read
    logic [DW-1:0] mem [0:(1<<AW)-1];
    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    end
    always @(posedge clk) begin
        if (!bus.ce_b && bus.wr_en_b) bus.dout_b <= mem[bus.addr_b];
        if (!bus.ce_a && !bus.wr_en_a)
            mem[bus.addr_a] <= (mem[bus.addr_a] & bus.bit_en_a) | (bus.din_a & ~bus.bit_en_a);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.in_eol = 1'b0; bus.out_ready = 1'b1;
        step();
        step();
        #1;
        n_cmp++;
        if ({bus.out_valid, bus.out_eol, bus.out_eof, bus.out_cur, bus.err_eol, bus.out_prev_vld} !== 13'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got v=%b eol=%b eof=%b cur=%h err=%b pv=%b, want all 0",
                     bus.out_valid, bus.out_eol, bus.out_eof, bus.out_cur, bus.err_eol, bus.out_prev_vld);
        end
        n_cmp++;
        if ({bus.ce_a, bus.wr_en_a, bus.bit_en_a, bus.addr_a, bus.din_a} !== {1'b1, 1'b1, 8'hFF, 10'd0, 8'd0}) begin
            n_err++;
            $display("FAIL reset_port_a: got ce=%b we=%b be=%h addr=%h din=%h, want 1 1 ff 000 00",
                     bus.ce_a, bus.wr_en_a, bus.bit_en_a, bus.addr_a, bus.din_a);
        end
        n_cmp++;
        if ({bus.in_ready, bus.ce_b, bus.wr_en_b} !== 3'b111) begin
            n_err++;
            $display("FAIL reset_ready_port_b: got rdy=%b ce_b=%b we_b=%b, want 1 1 1",
                     bus.in_ready, bus.ce_b, bus.wr_en_b);
        end
        rst_n = 1'b1;
    endtask

    // full 4x3 frame at one pixel per cycle, checking SRAM pins every cycle
    task automatic test_stream();
        int n_out;
        int p;
        logic [DW-1:0] exp_prev;
        n_out = 0;
        for (int k = 0; k <= 12; k++) begin
            bus.in_valid = (k < 12);
            bus.in_data  = DW'(k);
            bus.in_eol   = ((k % 4) == 3);
            #1;
            if (k < 12) begin
                n_cmp++;
                if ({bus.ce_b, bus.wr_en_b, bus.addr_b} !== {1'b0, 1'b1, AW'(k % 4)}) begin
                    n_err++;
                    $display("FAIL stream_port_b k=%0d: got ce=%b we=%b addr=%h, want 0 1 %h",
                             k, bus.ce_b, bus.wr_en_b, bus.addr_b, k % 4);
                end
            end
            if (k >= 1) begin
                p = k - 1;
                exp_prev = (p >= 4) ? DW'(p - 4) : '0;
                n_cmp++;
                if ({bus.ce_a, bus.wr_en_a, bus.bit_en_a, bus.addr_a, bus.din_a} !==
                    {1'b0, 1'b0, 8'h00, AW'(p % 4), DW'(p)}) begin
                    n_err++;
                    $display("FAIL stream_port_a k=%0d: got ce=%b we=%b be=%h addr=%h din=%h, want 0 0 00 %h %h",
                             k, bus.ce_a, bus.wr_en_a, bus.bit_en_a, bus.addr_a, bus.din_a, p % 4, p);
                end
                n_cmp++;
                if ({bus.out_valid, bus.out_cur, bus.out_prev, bus.out_prev_vld, bus.out_eol, bus.out_eof} !==
                    {1'b1, DW'(p), exp_prev, (p >= 4), ((p % 4) == 3), (p == 11)}) begin
                    n_err++;
                    $display("FAIL stream_out k=%0d: got v=%b cur=%h prev=%h pv=%b eol=%b eof=%b, want 1 %h %h %b %b %b",
                             k, bus.out_valid, bus.out_cur, bus.out_prev, bus.out_prev_vld, bus.out_eol, bus.out_eof,
                             p, exp_prev, (p >= 4), ((p % 4) == 3), (p == 11));
                end
            end else begin
                n_cmp++;
                if ({bus.out_valid, bus.ce_a} !== 2'b01) begin
                    n_err++;
                    $display("FAIL stream_first_cycle: got v=%b ce_a=%b, want 0 1", bus.out_valid, bus.ce_a);
                end
            end
            if (!bus.ce_a && !bus.ce_b) begin
                n_cmp++;
                if (bus.addr_a === bus.addr_b) begin
                    n_err++;
                    $display("FAIL stream_addr_collision k=%0d: got addr_a=addr_b=%h, want different", k, bus.addr_a);
                end
            end
            if (bus.out_valid) n_out++;
            step();
        end
        n_cmp++;
        if ({bus.out_valid, bus.ce_a, n_out == 12} !== 3'b011) begin
            n_err++;
            $display("FAIL stream_end: got v=%b ce_a=%b outputs=%0d, want 0 1 12", bus.out_valid, bus.ce_a, n_out);
        end
    endtask

    // stall 5 cycles once pixel 0x05 is on the output
    task automatic test_backpressure();
        int p, consumed, writes, reads, stall_left;
        bit stalled;
        logic [DW-1:0] exp_prev;
        p = 0; consumed = 0; writes = 0; reads = 0; stall_left = 0; stalled = 0;
        for (int cyc = 0; cyc < 60 && consumed < 12; cyc++) begin
            if (!stalled && bus.out_valid && bus.out_cur == 8'h05) begin
                stalled = 1;
                stall_left = 5;
            end
            bus.out_ready = (stall_left == 0);
            bus.in_valid  = (p < 12);
            bus.in_data   = DW'(p);
            bus.in_eol    = ((p % 4) == 3);
            #1;
            if (!bus.ce_a) writes++;
            if (!bus.ce_b) reads++;
            if (stall_left > 0) begin
                n_cmp++;
                if ({bus.in_ready, bus.ce_b, bus.out_valid, bus.out_cur, bus.out_prev} !==
                    {1'b0, 1'b1, 1'b1, 8'h05, 8'h01}) begin
                    n_err++;
                    $display("FAIL stall_hold left=%0d: got rdy=%b ce_b=%b v=%b cur=%h prev=%h, want 0 1 1 05 01",
                             stall_left, bus.in_ready, bus.ce_b, bus.out_valid, bus.out_cur, bus.out_prev);
                end
                if (stall_left < 5) begin
                    n_cmp++;
                    if (bus.ce_a !== 1'b1) begin
                        n_err++;
                        $display("FAIL stall_port_a_idle left=%0d: got ce_a=%b, want 1", stall_left, bus.ce_a);
                    end
                end
                stall_left--;
            end
            if (bus.out_valid && bus.out_ready) begin
                exp_prev = (consumed >= 4) ? DW'(consumed - 4) : '0;
                n_cmp++;
                if ({bus.out_cur, bus.out_prev, bus.out_prev_vld, bus.out_eof} !==
                    {DW'(consumed), exp_prev, (consumed >= 4), (consumed == 11)}) begin
                    n_err++;
                    $display("FAIL bp_out idx=%0d: got cur=%h prev=%h pv=%b eof=%b, want %h %h %b %b",
                             consumed, bus.out_cur, bus.out_prev, bus.out_prev_vld, bus.out_eof,
                             consumed, exp_prev, (consumed >= 4), (consumed == 11));
                end
                consumed++;
            end
            if (bus.in_valid && bus.in_ready) p++;
            step();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        n_cmp++;
        if (stalled != 1'b1 || consumed != 12 || writes != 12 || reads != 12 || p != 12) begin
            n_err++;
            $display("FAIL bp_totals: got stalled=%0d consumed=%0d writes=%0d reads=%0d sent=%0d, want 1 12 12 12 12",
                     stalled, consumed, writes, reads, p);
        end
    endtask

    // in_eol at row 0 col 2: resync to row 1 col 0
    task automatic test_eol_err();
        logic [DW-1:0] dat [4];
        logic          eol [4];
        dat = '{8'h20, 8'h21, 8'h22, 8'h30};
        eol = '{1'b0, 1'b0, 1'b1, 1'b0};
        for (int k = 0; k <= 4; k++) begin
            bus.in_valid = (k < 4);
            bus.in_data  = (k < 4) ? dat[k] : '0;
            bus.in_eol   = (k < 4) ? eol[k] : 1'b0;
            #1;
            if (k == 2) begin
                n_cmp++;
                if (bus.err_eol !== 1'b0) begin
                    n_err++;
                    $display("FAIL eol_err_before: got err=%b, want 0", bus.err_eol);
                end
            end
            if (k == 3) begin
                n_cmp++;
                if ({bus.err_eol, bus.out_cur, bus.out_eol} !== {1'b1, 8'h22, 1'b0}) begin
                    n_err++;
                    $display("FAIL eol_err_set: got err=%b cur=%h eol=%b, want 1 22 0",
                             bus.err_eol, bus.out_cur, bus.out_eol);
                end
            end
            if (k == 4) begin
                n_cmp++;
                if ({bus.out_valid, bus.out_cur, bus.out_prev_vld, bus.out_prev, bus.err_eol} !==
                    {1'b1, 8'h30, 1'b1, 8'h20, 1'b1}) begin
                    n_err++;
                    $display("FAIL eol_resync: got v=%b cur=%h pv=%b prev=%h err=%b, want 1 30 1 20 1",
                             bus.out_valid, bus.out_cur, bus.out_prev_vld, bus.out_prev, bus.err_eol);
                end
            end
            step();
        end
        bus.in_valid = 1'b0;
    endtask

    // reset after 7 pixels with a pixel still offered, then restart a frame
    task automatic test_reset_mid();
        for (int k = 0; k < 7; k++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = DW'(k);
            bus.in_eol   = 1'b0;
            step();
        end
        rst_n        = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h07;
        step();
        n_cmp++;
        if ({bus.ce_a, bus.wr_en_a, bus.bit_en_a, bus.out_valid, bus.err_eol} !==
            {1'b1, 1'b1, 8'hFF, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL midreset_state: got ce_a=%b we_a=%b be=%h v=%b err=%b, want 1 1 ff 0 0",
                     bus.ce_a, bus.wr_en_a, bus.bit_en_a, bus.out_valid, bus.err_eol);
        end
        rst_n = 1'b1;
        for (int k = 0; k <= 4; k++) begin
            bus.in_valid = (k < 4);
            bus.in_data  = DW'(k);
            bus.in_eol   = (k == 3);
            #1;
            if (k >= 1) begin
                n_cmp++;
                if ({bus.out_valid, bus.out_cur, bus.out_prev_vld, bus.out_prev, bus.err_eol} !==
                    {1'b1, DW'(k - 1), 1'b0, 8'h00, 1'b0}) begin
                    n_err++;
                    $display("FAIL midreset_row0 k=%0d: got v=%b cur=%h pv=%b prev=%h err=%b, want 1 %h 0 00 0",
                             k, bus.out_valid, bus.out_cur, bus.out_prev_vld, bus.out_prev, bus.err_eol, k - 1);
                end
            end
            step();
        end
        bus.in_valid = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_stream();
        test_backpressure();
        test_eol_err();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end
endmodule

// File: doc/sgm_line_buf_ctrl.md
Name: sgm_line_buf_ctrl

Overview:
- Streaming controller that turns one pixel/cost stream into vertically aligned pixel pairs: the current pixel plus the pixel in the same column of the previous row.
- Uses an external one-line dual-port bit-enable SRAM, IMG_WIDTH deep. Port A is write-only and port B is read-only.
- Sits upstream of the SRAM and feeds the SGM vertical-path aggregation stage through a valid/ready interface.

Parameters:
- DATA_WIDTH, 8: pixel/cost word width; equals the SRAM DATA_WIDTH.
- ADDR_WIDTH, 10: SRAM address width; must satisfy 2^ADDR_WIDTH >= IMG_WIDTH.
- IMG_WIDTH, 640: columns per row; must be >= 2.
- IMG_HEIGHT, 480: rows per frame; must be >= 1.

Ports:
- clk  in  1  single clock for all logic and both SRAM ports.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  input pixel valid.
- in_ready  out  1  input pixel accepted when in_valid && in_ready.
- in_data  in  DATA_WIDTH  input pixel.
- in_eol  in  1  marks the last pixel of a row.
- out_valid  out  1  output pair valid.
- out_ready  in  1  downstream ready.
- out_cur  out  DATA_WIDTH  current-row pixel.
- out_prev  out  DATA_WIDTH  previous-row pixel at the same column; 0 on row 0.
- out_prev_vld  out  1  0 on row 0, else 1.
- out_eol  out  1  output pair is the last column of its row.
- out_eof  out  1  output pair is the last pixel of the frame.
- err_eol  out  1  sticky flag: in_eol position did not match IMG_WIDTH.
- addr_a  out  ADDR_WIDTH  SRAM port A address.
- din_a  out  DATA_WIDTH  SRAM port A write data.
- ce_a  out  1  SRAM port A chip enable, low-active.
- wr_en_a  out  1  SRAM port A write enable, low-active.
- bit_en_a  out  DATA_WIDTH  SRAM port A bit enable, low-active.
- addr_b  out  ADDR_WIDTH  SRAM port B address.
- ce_b  out  1  SRAM port B chip enable, low-active.
- wr_en_b  out  1  SRAM port B write enable, low-active.
- dout_b  in  DATA_WIDTH  SRAM port B read data, valid 1 cycle after the read.

Behaviour:
- Reset values:
  - ce_a, wr_en_a, bit_en_a = all 1s (port A idle); addr_a = 0; din_a = 0.
  - col = 0, row = 0.
  - out_valid, out_eol, out_eof, out_cur, err_eol = 0.
- Reset mid-frame: counters return to 0 and no SRAM write issues in the following cycle. The next accepted pixel is treated as row 0, col 0 (out_prev_vld = 0).
- Accept rule: in_ready = !out_valid || out_ready. The block holds at most one pair in flight, so backpressure needs no skid buffer.
- Accept in cycle t (column c):
  - Port B is combinational: ce_b = 0, wr_en_b = 1 (always), addr_b = col. The SRAM samples the read at the end of t.
  - When nothing is accepted, ce_b = 1.
  - Registered at the end of t: out_valid = 1, out_cur = in_data, out_eol = (c == IMG_WIDTH-1), out_eof = out_eol && (row == IMG_HEIGHT-1), out_prev_vld = (row != 0).
  - Write pending: in cycle t+1 the block drives ce_a = 0, wr_en_a = 0, bit_en_a = all 0, addr_a = c, din_a = pixel c. These are registered and held for exactly one cycle, then return to idle (all 1s).
- Ordering guarantee:
  - Column c is read (end of t) before it is overwritten (end of t+1), so out_prev always holds the old row.
  - The port A write in t+1 and the port B read in t+1 use different addresses: c vs c+1, or W-1 vs 0 at row wrap. Same-address access never occurs.
- Output data:
  - out_prev = out_prev_vld ? dout_b : 0, combinational.
  - dout_b stays stable while stalled because no new read issues when in_ready = 0.
- Output release: out_valid clears on out_valid && out_ready unless a new accept occurs in the same cycle. Simultaneous consume and accept keeps out_valid = 1 with the new pair, giving 1 pair/cycle sustained.
- Counters advance on accept:
  - col wraps at IMG_WIDTH-1 to 0 and increments row.
  - row wraps at IMG_HEIGHT-1 to 0.
- in_eol check:
  - in_eol = 1 at col != IMG_WIDTH-1: set err_eol, force col to 0, increment row (resync).
  - Col reaches IMG_WIDTH-1 without in_eol: set err_eol; wrap normally.
  - err_eol clears only on reset.
- Latency: an accepted pixel appears on out_* in the next cycle.

Test Plan (IMG_WIDTH = 4, IMG_HEIGHT = 3, DATA_WIDTH = 8, out_ready = 1 unless noted):
- Stream pixels 0x00..0x0B continuously:
  - Row 0 outputs prev_vld = 0, prev = 0.
  - Row 1 outputs pairs (0x04,0x00)..(0x07,0x03); row 2 outputs (0x08,0x04)..(0x0B,0x07).
  - out_eof = 1 only with 0x0B; 12 outputs in 13 cycles.
- Check SRAM pins on every cycle of the same stream:
  - Port A write appears exactly 1 cycle after each accept with the matching addr/data and bit_en_a = 0x00.
  - addr_a never equals addr_b while ce_a = 0 and ce_b = 0.
- Hold out_ready = 0 for 5 cycles after the 6th pixel:
  - in_ready = 0 throughout; out_cur/out_prev stay (0x05,0x01).
  - No extra port A/B accesses; the stream resumes with no loss or duplication.
- Assert in_eol on row 0 col 2:
  - err_eol = 1.
  - The next pixel is output with prev_vld = 1 and the prev data of col 0.
- Assert rst_n = 0 for 1 cycle after the 7th pixel, then restream from 0x00:
  - Port A is idle during the reset cycle.
  - The first 4 outputs after reset have out_prev_vld = 0; err_eol = 0.
